// File: rtl/gain_arbiter.sv
// Shares a single gain multiplier between two audio channels. Samples are
// popped from show-ahead input FIFOs in round-robin order, scaled by a
// per-channel runtime gain, shifted left by OUT_SHIFT and written to the
// output FIFO of the same channel.
module gain_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int GAIN_DEFAULT = 1,
    parameter int OUT_SHIFT    = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [1:0]              in_empty,
    input  logic [2*DATA_WIDTH-1:0] in_dout,
    output logic [1:0]              in_rd_en,
    input  logic [1:0]              out_full,
    output logic [DATA_WIDTH-1:0]   out_din,
    output logic [1:0]              out_wr_en,
    input  logic                    gain_wr_en,
    input  logic                    gain_sel,
    input  logic [31:0]             gain_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                        state;
    logic                          ptr;        // channel favoured when both are ready
    logic                          chan_r;
    logic [DATA_WIDTH-1:0]         sample_r;
    logic [31:0]                   gain_r;
    logic [DATA_WIDTH-1:0]         prod_r;

    logic [1:0][31:0]              gain;
    logic [1:0][31:0]              pend;
    logic [1:0]                    pend_vld;
    logic [1:0][31:0]              gain_eff;

    logic [1:0][DATA_WIDTH-1:0]    in_words;
    logic [1:0]                    ready;
    logic                          grant_vld;
    logic                          grant_chan;
    logic [63:0]                   sample_ext;
    logic [63:0]                   gain_ext;
    logic [DATA_WIDTH-1:0]         prod_next;

    assign in_words = in_dout;

    // A channel can be served only if it has data and somewhere to put the result.
    assign ready      = ~in_empty & ~out_full;
    // Single ready channel wins outright; on a tie the pointer decides.
    assign grant_chan = (ready == 2'b11) ? ptr : ready[1];
    // Pops are held off while reset is asserted so every output reads 0 in reset.
    assign grant_vld  = reset_n && (state == IDLE) && (ready != 2'b00);
    assign in_rd_en   = grant_vld ? (2'b01 << grant_chan) : 2'b00;

    // Writes wait on the downstream FIFO; the sample is held, never dropped.
    assign out_wr_en  = ((state == WRITE) && !out_full[chan_r]) ? (2'b01 << chan_r) : 2'b00;
    // prod_r only changes on the MUL->WRITE edge, so it also holds the last
    // written word whenever the FSM is outside WRITE.
    assign out_din    = prod_r;
    assign busy       = (state != IDLE);

    // A pending gain is visible to a grant in the same IDLE cycle it commits,
    // so a write lands on the very next grant; a write in the grant cycle
    // itself only reaches pend at the clock edge and therefore misses it.
    assign gain_eff[0] = pend_vld[0] ? pend[0] : gain[0];
    assign gain_eff[1] = pend_vld[1] ? pend[1] : gain[1];

    // Full 64-bit signed product, then scale and keep the low word (wraps).
    assign sample_ext = {{(64-DATA_WIDTH){sample_r[DATA_WIDTH-1]}}, sample_r};
    assign gain_ext   = {{32{gain_r[31]}}, gain_r};
    assign prod_next  = DATA_WIDTH'((sample_ext * gain_ext) << OUT_SHIFT);

    // Gain config: stage writes in pend, commit them whenever the FSM idles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gain     <= {2{32'(GAIN_DEFAULT)}};
            pend     <= '0;
            pend_vld <= '0;
        end else begin
            if (state == IDLE) begin
                gain     <= gain_eff;
                pend_vld <= 2'b00;
            end
            // Placed after the commit so a new write survives a same-cycle commit.
            if (gain_wr_en) begin
                pend[gain_sel]     <= gain_data;
                pend_vld[gain_sel] <= 1'b1;
            end
        end
    end

    // Sample FSM: grant/capture, multiply, then write with backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            chan_r   <= 1'b0;
            sample_r <= '0;
            gain_r   <= '0;
            prod_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        sample_r <= in_words[grant_chan];
                        gain_r   <= gain_eff[grant_chan];
                        chan_r   <= grant_chan;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    prod_r <= prod_next;
                    state  <= WRITE;
                end
                WRITE: begin
                    if (!out_full[chan_r]) begin
                        ptr   <= ~chan_r;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gain_arbiter.sv
// Bench for gain_arbiter: input FIFO models, a scoreboard filled at each pop
// from a reference model (arbitration rule + per-channel gain in effect),
// and a monitor that checks every write, stall and idle cycle against it.
module tb_gain_arbiter;

    localparam int DW    = 32;
    localparam int SHIFT = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    in_empty;
    logic [2*DW-1:0] in_dout;
    logic [1:0]    in_rd_en;
    logic [1:0]    out_full;
    logic [DW-1:0] out_din;
    logic [1:0]    out_wr_en;
    logic          gain_wr_en;
    logic          gain_sel;
    logic [31:0]   gain_data;
    logic          busy;

    gain_arbiter #(.DATA_WIDTH(DW), .GAIN_DEFAULT(1), .OUT_SHIFT(SHIFT)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
        .out_full(out_full), .out_din(out_din), .out_wr_en(out_wr_en),
        .gain_wr_en(gain_wr_en), .gain_sel(gain_sel), .gain_data(gain_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ch;
        logic [31:0] data;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    exp_t        exp_q[$];
    logic [31:0] mgain[2];
    logic        mptr = 1'b0;
    bit          inflight = 0;
    bit          iblk = 0;
    logic        ichan = 1'b0;
    int          icyc = 0;
    int          pops_seen[2];
    int          pops_applied[2];
    int          wr_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] last_wr = '0;
    int          last_wr_cyc = 0;
    int          grant_log[$];
    int          pop_cyc_log[$];

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: sample times gain as 64-bit signed integers, scaled, low word kept.
    function automatic logic [31:0] model_out(logic [31:0] s, logic [31:0] g);
        longint p;
        p = longint'($signed(s)) * longint'($signed(g));
        return 32'(p <<< SHIFT);
    endfunction

    function automatic logic [31:0] head(int c);
        if (c == 0) return (q0.size() != 0) ? q0[0] : 32'h0;
        return (q1.size() != 0) ? q1[0] : 32'h0;
    endfunction

    task automatic drive();
        in_empty[0]     = (q0.size() == 0);
        in_empty[1]     = (q1.size() == 0);
        in_dout[DW-1:0] = head(0);
        in_dout[2*DW-1:DW] = head(1);
    endtask

    task automatic push(int c, logic [31:0] v);
        if (c == 0) q0.push_back(v); else q1.push_back(v);
        drive();
    endtask

    // Advance one cycle: retire FIFO entries the DUT popped, refresh FIFO heads.
    task automatic tick();
        @(posedge clock);
        #1;
        while (pops_applied[0] < pops_seen[0]) begin
            if (q0.size() != 0) void'(q0.pop_front());
            pops_applied[0]++;
        end
        while (pops_applied[1] < pops_seen[1]) begin
            if (q1.size() != 0) void'(q1.pop_front());
            pops_applied[1]++;
        end
        drive();
    endtask

    task automatic cfg(logic c, logic [31:0] v);
        gain_wr_en = 1'b1;
        gain_sel   = c;
        gain_data  = v;
        tick();
        gain_wr_en = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        for (int n = 0; n < budget; n++) begin
            if (q0.size() == 0 && q1.size() == 0 && !inflight) return;
            tick();
        end
        chk("drain_timeout", 1, 0);
    endtask

    // Monitor: compares DUT behaviour each cycle against the model.
    task automatic monitor_loop();
        logic [1:0] rdy;
        logic [1:0] exp_rd;
        exp_t       e;
        exp_t       ne;
        logic       c;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                exp_q.delete();
                inflight = 0;
                iblk     = 0;
                mptr     = 1'b0;
                mgain[0] = 32'd1;
                mgain[1] = 32'd1;
                last_wr  = '0;
            end else begin
                chk("busy", busy, inflight);
                rdy = ~in_empty & ~out_full;
                if (!inflight) begin
                    exp_rd = (rdy == 2'b11) ? (mptr ? 2'b10 : 2'b01) : rdy;
                    chk("grant", in_rd_en, exp_rd);
                    if ((in_rd_en == 2'b01 || in_rd_en == 2'b10) && !in_empty[in_rd_en[1]]) begin
                        c       = in_rd_en[1];
                        ne.ch   = c;
                        ne.data = model_out(head(int'(c)), mgain[c]);
                        exp_q.push_back(ne);
                        pops_seen[c]++;
                        inflight = 1;
                        iblk     = 0;
                        ichan    = c;
                        icyc     = cyc;
                        grant_log.push_back(int'(c));
                        pop_cyc_log.push_back(cyc);
                        pop_cnt++;
                    end
                end else begin
                    chk("no_pop_busy", in_rd_en, 0);
                end

                if (out_wr_en != 2'b00) begin
                    if (!inflight || exp_q.size() == 0) begin
                        chk("unexpected_wr", out_wr_en, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_en", out_wr_en, e.ch ? 2'b10 : 2'b01);
                        chk("wr_full", out_full[e.ch], 0);
                        chk("wr_data", out_din, e.data);
                        if (!iblk) chk("latency", cyc - icyc, 2);
                        mptr        = ~e.ch;
                        inflight    = 0;
                        last_wr     = out_din;
                        last_wr_cyc = cyc;
                        wr_cnt++;
                    end
                end else if (inflight && (cyc - icyc) >= 2) begin
                    chk("stall", out_full[ichan], 1);
                    iblk = 1;
                end else begin
                    chk("hold", out_din, last_wr);
                end

                if (gain_wr_en) mgain[gain_sel] = gain_data;
            end
        end
    endtask

    task automatic main_seq();
        int p0;
        int w0;
        // ---- reset state, single ch0 sample queued while still in reset
        out_full   = 2'b00;
        gain_wr_en = 1'b0;
        gain_sel   = 1'b0;
        gain_data  = '0;
        drive();
        push(0, 32'h3);
        tick();
        chk("rst_rd_en", in_rd_en, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_out_din", out_din, 0);
        chk("rst_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        wait_drain(20);
        chk("t1_data", last_wr, 32'h30);
        chk("t1_latency", last_wr_cyc - pop_cyc_log[0], 2);

        // ---- both FIFOs with 4 samples, alternating grants, 8 writes in 24 cycles
        p0 = pop_cnt;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            push(0, 32'(i + 1));
            push(1, 32'(100 + i));
        end
        wait_drain(60);
        chk("t2_writes", wr_cnt - w0, 8);
        if (pop_cyc_log.size() > p0) chk("t2_span", last_wr_cyc - pop_cyc_log[p0], 23);
        for (int i = 0; i < 7; i++)
            if (grant_log.size() > p0 + i + 1)
                chk("t2_alternate", grant_log[p0+i] != grant_log[p0+i+1], 1);

        // ---- negative gain and wrap-around
        cfg(1'b1, 32'hFFFF_FFFD);
        push(1, 32'hFFFF_FFFB);
        wait_drain(20);
        chk("t3_neg", last_wr, 32'hF0);
        cfg(1'b0, 32'h4000_0000);
        push(0, 32'h4);
        wait_drain(20);
        chk("t3_wrap", last_wr, 32'h0);

        // ---- output backpressure for 10 WRITE cycles
        p0 = pop_cnt;
        push(0, 32'h11);
        push(0, 32'h22);
        tick();
        out_full[0] = 1'b1;
        push(1, 32'h33);
        w0 = wr_cnt;
        repeat (11) tick();
        chk("t4_no_write", wr_cnt - w0, 0);
        chk("t4_no_pop", pop_cnt - p0, 1);
        chk("t4_busy", busy, 1);
        out_full[0] = 1'b0;
        wait_drain(30);
        chk("t4_writes", wr_cnt - w0, 3);
        if (grant_log.size() >= p0 + 3) begin
            chk("t4_next_ch1", grant_log[p0+1], 1);
            chk("t4_then_ch0", grant_log[p0+2], 0);
        end

        // ---- gain write in the same cycle as a grant
        cfg(1'b0, 32'h1);
        gain_wr_en = 1'b1;
        gain_sel   = 1'b0;
        gain_data  = 32'd7;
        push(0, 32'h1);
        tick();
        gain_wr_en = 1'b0;
        wait_drain(20);
        chk("t5_old_gain", last_wr, 32'h10);
        push(0, 32'h1);
        wait_drain(20);
        chk("t5_new_gain", last_wr, 32'h70);

        // ---- reset during MUL: in-flight ch1 sample lost, ch0 resumes at default gain
        push(0, 32'h5);
        push(1, 32'h2);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rd_en", in_rd_en, 0);
        chk("t6_wr_en", out_wr_en, 0);
        chk("t6_out_din", out_din, 0);
        chk("t6_busy", busy, 0);
        tick();
        tick();
        reset_n = 1'b1;
        w0 = wr_cnt;
        wait_drain(20);
        repeat (3) tick();
        chk("t6_writes", wr_cnt - w0, 1);
        chk("t6_default_gain", last_wr, 32'h50);

        // ---- randomized traffic, backpressure and gain updates
        for (int n = 0; n < 800; n++) begin
            gain_wr_en = 1'b0;
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 9) < 3 && (c == 0 ? q0.size() : q1.size()) < 4)
                    push(c, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000);
                if ($urandom_range(0, 7) == 0) out_full[c] = ~out_full[c];
            end
            if ($urandom_range(0, 19) == 0) begin
                gain_wr_en = 1'b1;
                gain_sel   = 1'($urandom_range(0, 1));
                gain_data  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
            end
            tick();
        end
        gain_wr_en = 1'b0;
        out_full   = 2'b00;
        wait_drain(200);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    initial begin
        pops_seen[0]    = 0;
        pops_seen[1]    = 0;
        pops_applied[0] = 0;
        pops_applied[1] = 0;
        mgain[0]        = 32'd1;
        mgain[1]        = 32'd1;
        fork
            monitor_loop();
            main_seq();
        join_any
    end

endmodule
